// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key schedule types, FSM states and round constants
package aes_pkg;
   localparam int NR = 10;
   typedef logic [0:3][0:3][7:0] rk_t;
   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
   // indexed directly by the round counter; entry 0 and 11..15 are never used as constants
   localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                        8'h40, 8'h80, 8'h1b, 8'h36, 40'h0};
endpackage

// File: rtl/aes_inv_key_sched_if.sv
// aes_inv_key_sched_if: key load and round-key read port of the key scheduler
interface aes_inv_key_sched_if;
   import aes_pkg::*;
   rk_t        key_in;
   logic       key_valid;
   logic       key_ready;
   rk_t        rk_out;
   logic [3:0] rk_idx;
   logic       rk_valid;
   logic       rk_req;
   logic       rk_restart;
   logic       busy;
   modport master (output key_in, key_valid, rk_req, rk_restart,
                   input  key_ready, rk_out, rk_idx, rk_valid, busy);
   modport slave  (input  key_in, key_valid, rk_req, rk_restart,
                   output key_ready, rk_out, rk_idx, rk_valid, busy);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box
module aes_sbox (
   input  logic [7:0] i_a,
   output logic [7:0] o_y
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   assign o_y = SBOX[i_a];
endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: expands an AES-128 key one round per cycle, then serves round keys 10 down to 0
module aes_inv_key_sched import aes_pkg::*; #(
   parameter int NR = 10
) (
   input logic                clk,
   input logic                rst,
   aes_inv_key_sched_if.slave bus
);
   state_t          r_state;
   logic [3:0]      r_rnd;
   logic [3:0]      r_ptr;
   rk_t             r_keys [0:NR];
   rk_t             w_prev;
   rk_t             w_next;
   logic [0:3][7:0] w_sub;
   logic            w_ready;
   assign w_prev = r_keys[r_rnd == 4'd0 ? 4'd0 : r_rnd - 4'd1];
   // SubWord(RotWord(col 3)): lane i takes row i+1 of the previous key's last column
   for (genvar i = 0; i < 4; i++) begin : g_sb
      aes_sbox u_sbox (.i_a(w_prev[(i + 1) % 4][3]), .o_y(w_sub[i]));
   end
   always_comb begin
      w_next = w_prev;
      for (int r = 0; r < 4; r++) begin
         w_next[r][0] = w_prev[r][0] ^ w_sub[r] ^ (r == 0 ? RCON[r_rnd] : 8'h00);
         for (int c = 1; c < 4; c++) w_next[r][c] = w_prev[r][c] ^ w_next[r][c-1];
      end
   end
   // the extra EXPAND cycle at r_rnd == NR+1 only hands over to READY
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_rnd   <= '0;
         r_ptr   <= '0;
      end else if (r_state == EXPAND) begin
         if (r_rnd <= 4'(NR)) r_keys[r_rnd] <= w_next;
         r_rnd <= r_rnd == 4'(NR + 1) ? 4'd0 : r_rnd + 4'd1;
         if (r_rnd == 4'(NR + 1)) begin
            r_state <= READY;
            r_ptr   <= 4'(NR);
         end
      end else if (bus.key_valid) begin
         r_keys[0] <= bus.key_in;
         r_rnd     <= 4'd1;
         r_state   <= EXPAND;
      end else if (r_state == READY) begin
         r_ptr <= bus.rk_restart ? 4'(NR) : !bus.rk_req ? r_ptr : r_ptr == 4'd0 ? 4'(NR) : r_ptr - 4'd1;
      end
   end
   assign w_ready       = r_state == READY;
   assign bus.rk_valid  = w_ready;
   assign bus.key_ready = r_state != EXPAND;
   assign bus.busy      = r_state == EXPAND;
   assign bus.rk_idx    = w_ready ? r_ptr : 4'd0;
   assign bus.rk_out    = w_ready ? r_keys[r_ptr] : '0;
endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; only the value 10 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port key_in, input, [7:0] [0:3][0:3], cipher key as state matrix [row][col]; column c is FIPS-197 word w[c].
REQ-005 SHALL have port key_valid, input, 1, load request for key_in.
REQ-006 SHALL have port key_ready, output, 1, high when key_in is accepted (IDLE or READY).
REQ-007 SHALL have port rk_out, output, [7:0] [0:3][0:3], current round key, same layout as key_in.
REQ-008 SHALL have port rk_idx, output, 4, round number of rk_out (10 down to 0).
REQ-009 SHALL have port rk_valid, output, 1, rk_out/rk_idx are valid (READY only).
REQ-010 SHALL have port rk_req, input, 1, consumer takes rk_out this cycle.
REQ-011 SHALL have port rk_restart, input, 1, rewind the read pointer to round 10.
REQ-012 SHALL have port busy, output, 1, high in EXPAND.

Function
REQ-013 SHALL implement FSM states IDLE, EXPAND and READY.
REQ-014 SHALL, in IDLE or READY with key_valid=1 at an edge, store key_in as entry 0, set round counter to 1 and go to EXPAND.
REQ-015 SHALL, in EXPAND, compute one round key per cycle into entry r (r=1..10) from entry r-1 per FIPS-197: temp = SubWord(RotWord(col 3)) XOR Rcon[r] on row 0; col0' = col0 ^ temp; colN' = colN ^ colN-1'.
REQ-016 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
REQ-017 SHALL, after writing entry 10, go to READY with rd_ptr=10; rk_valid rises exactly 11 cycles after the accepting edge.
REQ-018 SHALL drive rk_out = entry[rd_ptr] and rk_idx = rd_ptr combinationally from registered state in READY, and rk_out=0, rk_idx=0 otherwise.
REQ-019 SHALL decrement rd_ptr on each edge with rk_valid & rk_req; when rd_ptr=0 is consumed it wraps to 10 for the next block, staying in READY.
REQ-020 SHALL set rd_ptr=10 on rk_restart in READY; rk_restart has priority over rk_req in the same cycle.
REQ-021 SHALL, when key_valid and rk_req coincide in READY, take the key load; the read is dropped and rk_valid is 0 from the next cycle.
REQ-022 SHALL ignore key_valid, rk_req and rk_restart during EXPAND; key_ready=0 in EXPAND.
REQ-023 SHALL treat rk_req and rk_restart in IDLE as no-ops.

Reset
REQ-024 SHALL, on rst=1 at an edge, enter IDLE with rd_ptr=0 and round counter=0; from the next cycle key_ready=1, rk_valid=0, busy=0, rk_out=0, rk_idx=0.
REQ-025 SHALL abort EXPAND on reset mid-operation; the partial buffer is never presented as valid.
REQ-026 SHALL not require the key buffer to be reset; it is don't-care until rewritten.

Structure
REQ-027 SHALL place the state enum, the Rcon table, NR and the round-key matrix typedef in shared package aes_pkg.
REQ-028 SHALL instantiate sub-module aes_sbox, a combinational forward S-box, four times for SubWord.
REQ-029 SHALL hold 11 round-key entries in registers; no RAM macro.

Verification
REQ-030 SHALL check: key 2b7e151628aed2a6abf7158809cf4f3c -> rk_valid 11 cycles later, rk_idx=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 SHALL check: same key, 11 rk_req pulses -> idx 10..0; idx 1=a0fafe1788542cb123a339392a6c7605, idx 0=key; 12th read gives idx 10 (wrap).
REQ-032 SHALL check: rk_restart and rk_req together at idx 6 -> next idx 10.
REQ-033 SHALL check: rst asserted 5 cycles into EXPAND -> IDLE, rk_valid=0, key_ready=1; a reload then yields correct round 10.
REQ-034 SHALL check: key_valid with rk_req in READY using all-zero key -> rk_valid low for 11 cycles, then idx 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-035 SHALL check: key_valid pulsed during EXPAND -> ignored, and the result matches the original key.
